branch_ctrl: RTL and testbench

BRANCH_CTRL -- requirements
Module: branch_ctrl

---
 rtl/br_pkg.sv | 20 ++
 rtl/br_cond_eval.sv | 27 ++
 rtl/branch_ctrl.sv | 177 +++++++++++++++++
 tb/tb_branch_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared definitions for the branch controller: funct3 encodings, FSM states and the
// default flush length.
package br_pkg;

   localparam logic [2:0] F3Beq  = 3'b000;
   localparam logic [2:0] F3Bne  = 3'b001;
   localparam logic [2:0] F3Blt  = 3'b100;
   localparam logic [2:0] F3Bge  = 3'b101;
   localparam logic [2:0] F3Bltu = 3'b110;
   localparam logic [2:0] F3Bgeu = 3'b111;

   localparam int unsigned FlushCyclesDefault = 2;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StEval  = 2'd1,
      StFlush = 2'd2
   } state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluator; funct3 010/011 flag illegal and resolve
// as not-taken.
module br_cond_eval
   import br_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [31:0] RD1,
   input  logic [31:0] RD2,
   output logic        cond,
   output logic        illegal
);

   always_comb begin
      cond    = 1'b0;
      illegal = 1'b0;
      case (funct3)
         F3Beq:   cond = (RD1 == RD2);
         F3Bne:   cond = (RD1 != RD2);
         F3Blt:   cond = ($signed(RD1) < $signed(RD2));
         F3Bge:   cond = ($signed(RD1) >= $signed(RD2));
         F3Bltu:  cond = (RD1 < RD2);
         F3Bgeu:  cond = (RD1 >= RD2);
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution controller: IDLE -> EVAL -> (FLUSH) -> IDLE with registered outputs.
// Optional statistics counters are enabled by defining BRANCH_CTRL_STATS_EN.
module branch_ctrl
   import br_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES = FlushCyclesDefault
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        br_valid,
   output logic        br_ready,
   input  logic [2:0]  funct3,
   input  logic [31:0] RD1,
   input  logic [31:0] RD2,
   input  logic [31:0] PC,
   input  logic [31:0] Imm,
   output logic        done,
   output logic        taken,
   output logic [31:0] target,
   output logic        redirect,
   output logic        flush,
   output logic        illegal,
   output logic [31:0] br_count,
   output logic [31:0] taken_count
);

   localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);

   state_e      state_q, state_d;
   logic [2:0]  f3_q, f3_d;
   logic [31:0] rd1_q, rd1_d, rd2_q, rd2_d, pc_q, pc_d, imm_q, imm_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        ready_q, ready_d;
   logic        done_q, done_d;
   logic        taken_q, taken_d;
   logic        redirect_q, redirect_d;
   logic        flush_q, flush_d;
   logic        illegal_q, illegal_d;
   logic [31:0] target_q, target_d;
   logic        cond, cond_illegal;
   logic [31:0] sum;

   br_cond_eval u_cond (
      .funct3  (f3_q),
      .RD1     (rd1_q),
      .RD2     (rd2_q),
      .cond    (cond),
      .illegal (cond_illegal)
   );

   assign sum = pc_q + imm_q;

   always_comb begin
      state_d    = state_q;
      f3_d       = f3_q;
      rd1_d      = rd1_q;
      rd2_d      = rd2_q;
      pc_d       = pc_q;
      imm_d      = imm_q;
      cnt_d      = cnt_q;
      ready_d    = ready_q;
      done_d     = 1'b0;
      taken_d    = 1'b0;
      redirect_d = 1'b0;
      illegal_d  = 1'b0;
      flush_d    = flush_q;
      target_d   = target_q;
      case (state_q)
         StIdle: begin
            if (br_valid) begin
               f3_d    = funct3;
               rd1_d   = RD1;
               rd2_d   = RD2;
               pc_d    = PC;
               imm_d   = Imm;
               ready_d = 1'b0;
               state_d = StEval;
            end
         end
         StEval: begin
            done_d    = 1'b1;
            taken_d   = cond;
            illegal_d = cond_illegal;
            if (cond) begin
               redirect_d = 1'b1;
               target_d   = {sum[31:1], 1'b0};
               flush_d    = 1'b1;
               cnt_d      = FlushLoad;
               state_d    = StFlush;
            end else begin
               ready_d = 1'b1;
               state_d = StIdle;
            end
         end
         StFlush: begin
            // Last flush cycle: drop flush and reopen the handshake on the same edge.
            if (cnt_q <= 4'd1) begin
               flush_d = 1'b0;
               ready_d = 1'b1;
               cnt_d   = 4'd0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            flush_d = 1'b0;
            ready_d = 1'b1;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         f3_q       <= 3'd0;
         rd1_q      <= 32'd0;
         rd2_q      <= 32'd0;
         pc_q       <= 32'd0;
         imm_q      <= 32'd0;
         cnt_q      <= 4'd0;
         ready_q    <= 1'b1;
         done_q     <= 1'b0;
         taken_q    <= 1'b0;
         redirect_q <= 1'b0;
         flush_q    <= 1'b0;
         illegal_q  <= 1'b0;
         target_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         f3_q       <= f3_d;
         rd1_q      <= rd1_d;
         rd2_q      <= rd2_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
         cnt_q      <= cnt_d;
         ready_q    <= ready_d;
         done_q     <= done_d;
         taken_q    <= taken_d;
         redirect_q <= redirect_d;
         flush_q    <= flush_d;
         illegal_q  <= illegal_d;
         target_q   <= target_d;
      end
   end

   assign br_ready = ready_q;
   assign done     = done_q;
   assign taken    = taken_q;
   assign redirect = redirect_q;
   assign flush    = flush_q;
   assign illegal  = illegal_q;
   assign target   = target_q;

`ifdef BRANCH_CTRL_STATS_EN
   logic [31:0] br_cnt_q, tk_cnt_q;

   // Counted on the edge that raises done, so the counts track the visible pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_cnt_q <= 32'd0;
         tk_cnt_q <= 32'd0;
      end else begin
         if (done_d) br_cnt_q <= br_cnt_q + 32'd1;
         if (done_d && taken_d) tk_cnt_q <= tk_cnt_q + 32'd1;
      end
   end

   assign br_count    = br_cnt_q;
   assign taken_count = tk_cnt_q;
`else
   assign br_count    = 32'd0;
   assign taken_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: vector table plus reset and back-to-back sequences,
// with a scoreboard of expected resolutions.
module tb_branch_ctrl;

   localparam int unsigned FlushCycles = 2;
`ifdef BRANCH_CTRL_STATS_EN
   localparam bit StatsEn = 1'b1;
`else
   localparam bit StatsEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        br_valid = 1'b0;
   logic [2:0]  funct3 = 3'd0;
   logic [31:0] RD1 = 32'd0, RD2 = 32'd0, PC = 32'd0, Imm = 32'd0;
   logic        br_ready, done, taken, redirect, flush, illegal;
   logic [31:0] target, br_count, taken_count;

   branch_ctrl #(.FLUSH_CYCLES(FlushCycles)) dut (
      .clk         (clk),
      .rst         (rst),
      .br_valid    (br_valid),
      .br_ready    (br_ready),
      .funct3      (funct3),
      .RD1         (RD1),
      .RD2         (RD2),
      .PC          (PC),
      .Imm         (Imm),
      .done        (done),
      .taken       (taken),
      .target      (target),
      .redirect    (redirect),
      .flush       (flush),
      .illegal     (illegal),
      .br_count    (br_count),
      .taken_count (taken_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] rd1, rd2, pc, imm;
      logic        taken, illegal;
      logic [31:0] target;
   } vec_t;

   typedef struct {
      logic        taken, illegal;
      logic [31:0] target;
   } exp_t;

   exp_t        exp_q[$];
   int          hs_q[$];
   int          hs_hist[$];
   exp_t        cur_exp;
   vec_t        vecs[12];
   int          checks = 0, failures = 0, cyc = 0, last_hs = 0;
   int unsigned br_exp = 0, tk_exp = 0;
   logic [31:0] last_target = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // One clock: record handshakes, pop and compare the scoreboard on done.
   task automatic tick();
      logic hs;
      exp_t e;
      int   h;
      hs = br_valid && br_ready && !rst;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
         exp_q.push_back(cur_exp);
         hs_q.push_back(cyc);
         hs_hist.push_back(cyc);
         last_hs = cyc;
      end
      if (done) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_done actual=1 required=0 (cycle %0d)", cyc);
         end else begin
            e = exp_q.pop_front();
            h = hs_q.pop_front();
            chk("done_latency", 32'(cyc), 32'(h + 1));
            chk("taken", 32'(taken), 32'(e.taken));
            chk("illegal", 32'(illegal), 32'(e.illegal));
            chk("redirect", 32'(redirect), 32'(e.taken));
            if (e.taken) last_target = e.target;
            chk("target", target, last_target);
            br_exp++;
            if (e.taken) tk_exp++;
         end
      end else if (redirect) begin
         checks++;
         failures++;
         $display("FAIL spurious_redirect actual=1 required=0 (cycle %0d)", cyc);
      end
   endtask

   task automatic issue(input vec_t v);
      logic rdy;
      bit   ok;
      funct3   = v.f3;
      RD1      = v.rd1;
      RD2      = v.rd2;
      PC       = v.pc;
      Imm      = v.imm;
      cur_exp  = '{v.taken, v.illegal, v.target};
      br_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         rdy = br_ready;
         tick();
         if (rdy) ok = 1'b1;
      end
      br_valid = 1'b0;
      chk("handshake_seen", 32'(ok), 32'd1);
      chk("ready_low_in_eval", 32'(br_ready), 32'd0);
   endtask

   task automatic run_one(input vec_t v);
      int nfl;
      int rdy_cyc;
      issue(v);
      nfl = 0;
      rdy_cyc = -1;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (flush) nfl++;
         if (br_ready) begin
            rdy_cyc = cyc;
            break;
         end
      end
      chk("flush_cycles", 32'(nfl), v.taken ? 32'(FlushCycles) : 32'd0);
      chk("ready_return", 32'(rdy_cyc), 32'(last_hs + 1 + (v.taken ? int'(FlushCycles) : 0)));
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_stats(input string name);
      chk({name, "_br_count"}, br_count, StatsEn ? br_exp : 32'd0);
      chk({name, "_taken_count"}, taken_count, StatsEn ? tk_exp : 32'd0);
   endtask

   initial begin
      int n0;
      vecs[0]  = '{3'b000, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1, 1'b0, 32'h120};
      vecs[1]  = '{3'b100, 32'hFFFFFFFF, 32'h1, 32'h200, 32'h8, 1'b1, 1'b0, 32'h208};
      vecs[2]  = '{3'b110, 32'hFFFFFFFF, 32'h1, 32'h300, 32'h8, 1'b0, 1'b0, 32'h0};
      vecs[3]  = '{3'b010, 32'h7, 32'h7, 32'h400, 32'h4, 1'b0, 1'b1, 32'h0};
      vecs[4]  = '{3'b001, 32'h1, 32'h2, 32'hFFFFFFF0, 32'h13, 1'b1, 1'b0, 32'h2};
      vecs[5]  = '{3'b101, 32'h1, 32'hFFFFFFFF, 32'h1000, 32'hFFFFFFF0, 1'b1, 1'b0, 32'hFF0};
      vecs[6]  = '{3'b111, 32'h1, 32'hFFFFFFFF, 32'h500, 32'h4, 1'b0, 1'b0, 32'h0};
      vecs[7]  = '{3'b000, 32'h3, 32'h4, 32'h600, 32'h4, 1'b0, 1'b0, 32'h0};
      vecs[8]  = '{3'b011, 32'h9, 32'h1, 32'h700, 32'h4, 1'b0, 1'b1, 32'h0};
      vecs[9]  = '{3'b101, 32'h8, 32'h8, 32'h40, 32'h5, 1'b1, 1'b0, 32'h44};
      vecs[10] = '{3'b100, 32'h2, 32'h3, 32'h0, 32'h10, 1'b1, 1'b0, 32'h10};
      vecs[11] = '{3'b111, 32'hFFFFFFFF, 32'h1, 32'h20, 32'h2, 1'b1, 1'b0, 32'h22};

      // Reset values
      #12;
      chk("rst_br_ready", 32'(br_ready), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_taken", 32'(taken), 32'd0);
      chk("rst_redirect", 32'(redirect), 32'd0);
      chk("rst_flush", 32'(flush), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_target", target, 32'd0);
      chk_stats("rst");
      @(posedge clk);
      #1;
      rst = 1'b0;

      foreach (vecs[i]) run_one(vecs[i]);
      chk_stats("table");

      // Back-to-back BNE not-taken with br_valid held high
      funct3   = 3'b001;
      RD1      = 32'h9;
      RD2      = 32'h9;
      PC       = 32'h800;
      Imm      = 32'h4;
      cur_exp  = '{1'b0, 1'b0, 32'h0};
      n0       = hs_hist.size();
      br_valid = 1'b1;
      for (int i = 0; i < 20 && (hs_hist.size() - n0) < 2; i++) tick();
      br_valid = 1'b0;
      for (int i = 0; i < 10 && (exp_q.size() != 0 || !br_ready); i++) tick();
      chk("b2b_accepts", 32'(hs_hist.size() - n0), 32'd2);
      if (hs_hist.size() - n0 >= 2)
         chk("b2b_gap", 32'(hs_hist[n0 + 1] - hs_hist[n0]), 32'd2);
      chk("b2b_drained", 32'(exp_q.size()), 32'd0);
      chk_stats("b2b");

      // Reset during FLUSH
      issue(vecs[0]);
      tick();
      chk("pre_rst_flush", 32'(flush), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      br_exp = 0;
      tk_exp = 0;
      last_target = 32'd0;
      chk("rstf_flush", 32'(flush), 32'd0);
      chk("rstf_br_ready", 32'(br_ready), 32'd1);
      chk("rstf_target", target, 32'd0);
      chk_stats("rstf");
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("rstf_post_flush", 32'(flush), 32'd0);
      chk_stats("rstf_post");

      // Reset during EVAL abandons the branch
      issue(vecs[4]);
      #2;
      rst = 1'b1;
      exp_q.delete();
      hs_q.delete();
      #1;
      chk("rste_done", 32'(done), 32'd0);
      chk("rste_br_ready", 32'(br_ready), 32'd1);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("rste_target", target, 32'd0);
      chk_stats("rste");

      // Recovery after reset
      run_one(vecs[5]);
      chk_stats("final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
